// File: rtl/ex_muldiv_sequencer.sv
// Iterative unsigned MULTU/DIVU unit for the execute stage. It retires one bit per cycle
// into HI/LO and stalls the front of the pipeline until the result is committed.
module ex_muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             Start,
  input  logic [1:0]       MulDivOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  input  logic             Flush,
  output logic             Stall,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [CW-1:0]        r_cnt;
  logic                 r_is_div;
  logic [WIDTH-1:0]     r_b;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_hi, r_lo;
  logic                 r_dbz;

  logic                 w_valid_op, w_accept, w_div, w_div_zero, w_last;
  logic [WIDTH:0]       w_sum, w_rem;
  logic [WIDTH-1:0]     w_diff;
  logic [2*WIDTH-1:0]   w_acc_nxt;

  assign w_div      = (MulDivOp == 2'b10);
  assign w_valid_op = (MulDivOp == 2'b01) || w_div;
  assign w_accept   = (r_state == S_IDLE) && Start && w_valid_op && !Flush;
  assign w_div_zero = w_div && (Operand2 == '0);
  assign w_last     = (r_cnt == CW'(WIDTH - 1));

  assign Stall     = reset_n && (w_accept || (r_state == S_BUSY));
  assign Busy      = (r_state == S_BUSY);
  assign Done      = (r_state == S_DONE);
  assign DivByZero = r_dbz;
  assign HI        = r_hi;
  assign LO        = r_lo;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = w_div_zero ? S_DONE : S_BUSY;
      S_BUSY: begin
        if (Flush)       w_state_nxt = S_IDLE;
        else if (w_last) w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Shared accumulator: multiply shifts right adding the multiplicand into the upper half;
  // divide shifts left with a restoring trial subtract. Upper half -> HI, lower -> LO.
  always_comb begin
    w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_b};
    w_rem     = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    w_diff    = w_rem[WIDTH-1:0] - r_b;
    w_acc_nxt = r_acc;
    if (!r_is_div) begin
      if (r_acc[0]) w_acc_nxt = {w_sum, r_acc[WIDTH-1:1]};
      else          w_acc_nxt = {1'b0, r_acc[2*WIDTH-1:1]};
    end else if (w_rem >= {1'b0, r_b}) begin
      w_acc_nxt = {w_diff, r_acc[WIDTH-2:0], 1'b1};
    end else begin
      w_acc_nxt = {w_rem[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_b      <= '0;
      r_acc    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_dbz    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_is_div <= w_div;
            r_b      <= w_div ? Operand2 : Operand1;
            r_acc    <= {{WIDTH{1'b0}}, (w_div ? Operand1 : Operand2)};
            r_cnt    <= '0;
            r_dbz    <= w_div_zero;
            if (w_div_zero) begin
              r_hi <= Operand1;
              r_lo <= '1;
            end
          end
        end
        S_BUSY: begin
          if (!Flush) begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_hi <= w_acc_nxt[2*WIDTH-1:WIDTH];
              r_lo <= w_acc_nxt[WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
